sram_bus_arbiter: RTL and testbench

- N-channel successor to the single-port SRAM-to-bus control block.
- Accepts SRAM-style requests on NCH independent channels (inst, data, uncache, ...).
- Arbitrates them onto one SRAM-like master bus (req/addr_ok/data_ok).
- Returns read data and a one-cycle finish pulse per channel; only one bus transaction is in flight.

---
 rtl/sram_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: arbitrates NCH SRAM-style request channels onto a single
// SRAM-like master bus (req/addr_ok/data_ok) with one transaction in flight.
// Build option SRAM_ARB_RR_EN: round-robin arbitration. When undefined the
// arbiter is fixed priority, lowest channel index first.
module sram_bus_arbiter #(
    parameter int unsigned NCH = 3,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_req,
    input  logic [4*NCH-1:0]  ch_wen,
    input  logic [AW*NCH-1:0] ch_addr,
    input  logic [DW*NCH-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_accept,
    output logic [NCH-1:0]    ch_fin,
    output logic [DW-1:0]     ch_rdata,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    input  logic [DW-1:0]     bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);

    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [GW-1:0]   grant_q,     grant_d;
    logic [3:0]      wen_q,       wen_d;
    logic [NCH-1:0]  ch_accept_q, ch_accept_d;
    logic [NCH-1:0]  ch_fin_q,    ch_fin_d;
    logic [DW-1:0]   ch_rdata_q,  ch_rdata_d;
    logic            busy_q,      busy_d;
    logic            bus_req_q,   bus_req_d;
    logic            bus_wr_q,    bus_wr_d;
    logic [1:0]      bus_size_q,  bus_size_d;
    logic [AW-1:0]   bus_addr_q,  bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
`ifdef SRAM_ARB_RR_EN
    logic [GW-1:0]   rr_q,        rr_d;
`endif

    logic [GW-1:0]   grant_c;
    logic            grant_found_c;
    logic [31:0]     search_base_c;
    logic [31:0]     search_idx_c;
    logic [3:0]      sel_wen_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_wdata_c;

    // Byte-enable pattern to bus transfer size; irregular patterns use a word.
    function automatic logic [1:0] size_from_wen(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                    size = 2'd1;
            default:                             size = 2'd2;
        endcase
        return size;
    endfunction

    // Pick the first requesting channel, scanning upward from the search base.
    always_comb begin
`ifdef SRAM_ARB_RR_EN
        search_base_c = 32'(rr_q) + 32'd1;
`else
        search_base_c = 32'd0;
`endif
        grant_c       = '0;
        grant_found_c = 1'b0;
        search_idx_c  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            search_idx_c = (search_base_c + 32'(k)) % 32'(NCH);
            if (!grant_found_c && ch_req[GW'(search_idx_c)]) begin
                grant_c       = GW'(search_idx_c);
                grant_found_c = 1'b1;
            end
        end
    end

    // Route the granted channel's request fields.
    always_comb begin
        sel_wen_c   = '0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_c == GW'(i)) begin
                sel_wen_c   = ch_wen[4*i +: 4];
                sel_addr_c  = ch_addr[AW*i +: AW];
                sel_wdata_c = ch_wdata[DW*i +: DW];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/ADDR/DATA sequence.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        wen_d       = wen_q;
        ch_accept_d = '0;
        ch_fin_d    = '0;
        ch_rdata_d  = ch_rdata_q;
        bus_req_d   = bus_req_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
`ifdef SRAM_ARB_RR_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found_c) begin
                    grant_d     = grant_c;
                    wen_d       = sel_wen_c;
                    ch_accept_d = NCH'(1) << grant_c;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = |sel_wen_c;
                    bus_size_d  = size_from_wen(sel_wen_c);
                    bus_addr_d  = sel_addr_c;
                    bus_wdata_d = sel_wdata_c;
`ifdef SRAM_ARB_RR_EN
                    rr_d        = grant_c;
`endif
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    bus_req_d   = 1'b0;
                    bus_wr_d    = 1'b0;
                    bus_size_d  = 2'd0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    ch_rdata_d = (wen_q == 4'd0) ? bus_rdata : '0;
                    ch_fin_d   = NCH'(1) << grant_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            wen_q       <= '0;
            ch_accept_q <= '0;
            ch_fin_q    <= '0;
            ch_rdata_q  <= '0;
            busy_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'd0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
            rr_q        <= GW'(NCH - 1);
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            wen_q       <= wen_d;
            ch_accept_q <= ch_accept_d;
            ch_fin_q    <= ch_fin_d;
            ch_rdata_q  <= ch_rdata_d;
            busy_q      <= busy_d;
            bus_req_q   <= bus_req_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
`ifdef SRAM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign ch_accept = ch_accept_q;
    assign ch_fin    = ch_fin_q;
    assign ch_rdata  = ch_rdata_q;
    assign busy      = busy_q;
    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the bus protocol.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    ch_req;
    logic [4*NCH-1:0]  ch_wen;
    logic [AW*NCH-1:0] ch_addr;
    logic [DW*NCH-1:0] ch_wdata;
    logic [NCH-1:0]    ch_accept;
    logic [NCH-1:0]    ch_fin;
    logic [DW-1:0]     ch_rdata;
    logic              busy;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [DW-1:0]     bus_rdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;

    sram_bus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_wen(ch_wen), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_accept(ch_accept), .ch_fin(ch_fin), .ch_rdata(ch_rdata), .busy(busy),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // channel masters
    logic [NCH-1:0] pend;
    logic [3:0]     a_wen   [NCH];
    logic [31:0]    a_addr  [NCH];
    logic [31:0]    a_wdata [NCH];
    logic [NCH-1:0] mb_valid;
    logic [3:0]     mb_wen   [NCH];
    logic [31:0]    mb_addr  [NCH];
    logic [31:0]    mb_wdata [NCH];
    int             req_pct = 0;

    // bus slave behaviour
    int   addr_delay  = 0;
    int   data_delay  = 0;
    bit   noise       = 1'b0;
    bit   rand_delays = 1'b0;
    bit   rdata_rand  = 1'b1;
    logic [31:0] rdata_val = 32'h0;

    // transaction-level model
    bit          txn_open;
    bit          addr_done;
    int          stage_cyc;
    int          t_ch;
    logic [3:0]  t_wen;
    int          last_g;
    logic [NCH-1:0] exp_accept, exp_fin;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic        exp_busy, exp_req, exp_wr;
    logic [1:0]  exp_size;

    // observations for directed checks
    int          raise_cyc [NCH];
    int          acc_cyc   [NCH];
    int          fin_cyc   [NCH];
    int          fin_cnt   [NCH];
    logic [1:0]  snap_size [NCH];
    logic        snap_wr   [NCH];
    logic [31:0] snap_wdata[NCH];
    logic [31:0] fin_rdata [NCH];
    int          req_hi_cnt = 0;
    bit          log_grants = 1'b0;
    int          grant_log[$];
    bit          b2b_arm = 1'b0;
    int          b2b_fin_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] size_of(input logic [3:0] w);
        if ($countones(w) == 1) return 2'd0;
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    // First requesting channel in arbitration order, -1 if none.
    function automatic int pick(input logic [NCH-1:0] r, input int last);
        int c;
        for (int k = 1; k <= NCH; k++) begin
`ifdef SRAM_ARB_RR_EN
            c = (last + k) % NCH;
`else
            c = k - 1;
`endif
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic post(input int ch, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        mb_valid[ch] = 1'b1;
        mb_wen[ch]   = w;
        mb_addr[ch]  = a;
        mb_wdata[ch] = d;
    endtask

    task automatic model_reset();
        txn_open = 1'b0; addr_done = 1'b0; stage_cyc = 0; t_ch = 0; t_wen = 4'h0;
        last_g = NCH - 1;
        exp_accept = '0; exp_fin = '0; exp_rdata = '0; exp_busy = 1'b0;
        exp_req = 1'b0; exp_wr = 1'b0; exp_size = 2'd0; exp_addr = '0; exp_wdata = '0;
        pend = '0; mb_valid = '0;
        ch_req = '0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    endtask

    task automatic compare();
        chk("ch_accept", 64'(ch_accept), 64'(exp_accept));
        chk("ch_fin",    64'(ch_fin),    64'(exp_fin));
        chk("ch_rdata",  64'(ch_rdata),  64'(exp_rdata));
        chk("busy",      64'(busy),      64'(exp_busy));
        chk("bus_req",   64'(bus_req),   64'(exp_req));
        chk("bus_wr",    64'(bus_wr),    64'(exp_wr));
        chk("bus_size",  64'(bus_size),  64'(exp_size));
        chk("bus_addr",  64'(bus_addr),  64'(exp_addr));
        chk("bus_wdata", 64'(bus_wdata), 64'(exp_wdata));
        if (bus_req) req_hi_cnt++;
        for (int i = 0; i < NCH; i++) begin
            if (ch_accept[i]) begin
                acc_cyc[i]    = cyc;
                snap_size[i]  = bus_size;
                snap_wr[i]    = bus_wr;
                snap_wdata[i] = bus_wdata;
                if (log_grants) grant_log.push_back(i);
            end
            if (ch_fin[i]) begin
                fin_cyc[i]   = cyc;
                fin_cnt[i]   = fin_cnt[i] + 1;
                fin_rdata[i] = ch_rdata;
            end
        end
        if (b2b_arm && ch_fin[1]) begin
            b2b_arm     = 1'b0;
            b2b_fin_cyc = cyc;
            post(1, 4'h0, 32'h2000_0040, 32'h0);
        end
    endtask

    task automatic agents();
        for (int i = 0; i < NCH; i++) begin
            if (ch_accept[i] && pend[i]) begin
                pend[i] = 1'b0;
            end else if (!pend[i]) begin
                if (mb_valid[i]) begin
                    a_wen[i] = mb_wen[i]; a_addr[i] = mb_addr[i]; a_wdata[i] = mb_wdata[i];
                    mb_valid[i] = 1'b0; pend[i] = 1'b1; raise_cyc[i] = cyc;
                end else if ($urandom_range(0, 99) < req_pct) begin
                    a_wen[i]   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                    a_addr[i]  = $urandom;
                    a_wdata[i] = $urandom;
                    pend[i] = 1'b1; raise_cyc[i] = cyc;
                end
            end
            ch_wen[4*i +: 4]     = a_wen[i];
            ch_addr[AW*i +: AW]  = a_addr[i];
            ch_wdata[DW*i +: DW] = a_wdata[i];
        end
        ch_req = pend;
    endtask

    task automatic responder();
        bus_rdata   = rdata_rand ? $urandom : rdata_val;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (txn_open && !addr_done) begin
            bus_addr_ok = (stage_cyc > addr_delay);
            if (noise) bus_data_ok = 1'($urandom_range(0, 1));
        end else if (txn_open) begin
            bus_data_ok = (stage_cyc > data_delay);
            if (noise) bus_addr_ok = 1'($urandom_range(0, 1));
        end
    endtask

    // Predict the DUT outputs for the next cycle from the inputs now driven.
    task automatic advance();
        exp_accept = '0;
        exp_fin    = '0;
        if (!txn_open) begin
            if (pend != '0) begin
                t_ch      = pick(pend, last_g);
                last_g    = t_ch;
                t_wen     = a_wen[t_ch];
                txn_open  = 1'b1;
                addr_done = 1'b0;
                stage_cyc = 1;
                exp_accept[t_ch] = 1'b1;
                exp_req   = 1'b1;
                exp_wr    = |t_wen;
                exp_size  = size_of(t_wen);
                exp_addr  = a_addr[t_ch];
                exp_wdata = a_wdata[t_ch];
                if (rand_delays) begin
                    addr_delay = $urandom_range(0, 3);
                    data_delay = $urandom_range(0, 3);
                end
            end
        end else if (!addr_done) begin
            if (bus_addr_ok) begin
                addr_done = 1'b1; stage_cyc = 1;
                exp_req = 1'b0; exp_wr = 1'b0; exp_size = 2'd0; exp_addr = '0; exp_wdata = '0;
            end else begin
                stage_cyc++;
            end
        end else begin
            if (bus_data_ok) begin
                exp_rdata     = (t_wen == 4'h0) ? bus_rdata : 32'h0;
                exp_fin[t_ch] = 1'b1;
                txn_open      = 1'b0;
            end else begin
                stage_cyc++;
            end
        end
        exp_busy = txn_open;
    endtask

    task automatic tail();
        agents();
        responder();
        advance();
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare();
        tail();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k = 0;
        bit done = 1'b0;
        while (k < budget) begin
            if (!txn_open && pend == '0 && mb_valid == '0) begin
                done = 1'b1;
                break;
            end
            step();
            k++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_fin(input string tag, input int ch, input int target, input int budget);
        int k = 0;
        while (fin_cnt[ch] < target && k < budget) begin
            step();
            k++;
        end
        chk(tag, 64'(fin_cnt[ch] >= target), 64'd1);
    endtask

    int exp_list[6];
    int k;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            a_wen[i] = '0; a_addr[i] = '0; a_wdata[i] = '0;
            raise_cyc[i] = 0; acc_cyc[i] = 0; fin_cyc[i] = 0; fin_cnt[i] = 0;
        end
        ch_wen = '0; ch_addr = '0; ch_wdata = '0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // outputs while reset is held
        chk("rst_accept", 64'(ch_accept), 64'd0);
        chk("rst_fin",    64'(ch_fin),    64'd0);
        chk("rst_rdata",  64'(ch_rdata),  64'd0);
        chk("rst_busy",   64'(busy),      64'd0);
        chk("rst_req",    64'(bus_req),   64'd0);
        chk("rst_wr",     64'(bus_wr),    64'd0);
        chk("rst_size",   64'(bus_size),  64'd0);
        chk("rst_addr",   64'(bus_addr),  64'd0);
        chk("rst_wdata",  64'(bus_wdata), 64'd0);

        rst = 1'b0;
        tail();

        // all channels requesting continuously
`ifdef SRAM_ARB_RR_EN
        exp_list = '{0, 1, 2, 0, 1, 2};
`else
        exp_list = '{0, 0, 0, 0, 0, 0};
`endif
        req_pct = 100; log_grants = 1'b1;
        k = 0;
        while (grant_log.size() < 6 && k < 100) begin step(); k++; end
        req_pct = 0; log_grants = 1'b0;
        chk("cont_grants", 64'(grant_log.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("cont_grant%0d", i), 64'(grant_log[i]), 64'(exp_list[i]));
        run_until_idle("cont_drain", 200);

        // single word read, immediate handshakes
        rdata_rand = 1'b0; rdata_val = 32'hDEAD_BEEF;
        post(0, 4'h0, 32'h1000_0000, 32'h0);
        wait_fin("rd_done", 0, fin_cnt[0] + 1, 20);
        chk("rd_acc_lat", 64'(acc_cyc[0] - raise_cyc[0]), 64'd1);
        chk("rd_fin_lat", 64'(fin_cyc[0] - acc_cyc[0]), 64'd2);
        chk("rd_size",    64'(snap_size[0]), 64'd2);
        chk("rd_wr",      64'(snap_wr[0]),   64'd0);
        chk("rd_data",    64'(fin_rdata[0]), 64'hDEAD_BEEF);
        rdata_rand = 1'b1;

        // byte write with addr_ok held off three cycles
        addr_delay = 3; req_hi_cnt = 0;
        post(1, 4'b0100, 32'h1000_0002, 32'h00AB_0000);
        wait_fin("bw_done", 1, fin_cnt[1] + 1, 20);
        chk("bw_size",   64'(snap_size[1]),  64'd0);
        chk("bw_wr",     64'(snap_wr[1]),    64'd1);
        chk("bw_wdata",  64'(snap_wdata[1]), 64'h00AB_0000);
        chk("bw_rdata",  64'(fin_rdata[1]),  64'd0);
        chk("bw_req_cy", 64'(req_hi_cnt),    64'd4);
        addr_delay = 0;

        // half-word and irregular byte-enable sizes
        post(2, 4'b1100, 32'h1000_0010, 32'h1234_0000);
        wait_fin("hw_done", 2, fin_cnt[2] + 1, 20);
        chk("hw_size", 64'(snap_size[2]), 64'd1);
        post(0, 4'b0110, 32'h1000_0020, 32'h0055_6600);
        wait_fin("odd_done", 0, fin_cnt[0] + 1, 20);
        chk("odd_size", 64'(snap_size[0]), 64'd2);

        // channel 1 re-requests in its own finish cycle
        b2b_arm = 1'b1;
        post(1, 4'h0, 32'h2000_0000, 32'h0);
        wait_fin("b2b_done", 1, fin_cnt[1] + 2, 30);
        chk("b2b_gap", 64'(acc_cyc[1] - b2b_fin_cyc), 64'd1);

        // reset while waiting for data_ok
        data_delay = 1000;
        post(0, 4'h0, 32'h3000_0000, 32'h0);
        k = 0;
        while (!(txn_open && addr_done) && k < 20) begin step(); k++; end
        chk("rst_mid_reach", 64'(txn_open && addr_done), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req",  64'(bus_req), 64'd0);
        chk("rst_mid_busy", 64'(busy),    64'd0);
        chk("rst_mid_fin",  64'(ch_fin),  64'd0);
        model_reset();
        data_delay = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_fin", 64'(ch_fin),  64'd0);
            chk("rst_hold_req", 64'(bus_req), 64'd0);
        end
        rst = 1'b0;
        post(2, 4'h0, 32'h3000_0100, 32'h0);
        tail();
        wait_fin("post_rst_ch2", 2, fin_cnt[2] + 1, 20);

        // random traffic with random handshake delays and ignored noise
        req_pct = 25; rand_delays = 1'b1; noise = 1'b1;
        repeat (1500) step();
        req_pct = 0;
        run_until_idle("rand_drain", 300);
        rand_delays = 1'b0; noise = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
